// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the serial program loader and the processor fetch side.
package prog_loader_pkg;

  typedef enum logic [2:0] {
    IDLE, GET_CNT, GET_DATA, GET_CKSUM, FILL, DONE, ERR
  } load_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_COUNT = 2'd1;
  localparam logic [1:0] ERR_CKSUM = 2'd2;
  localparam logic [1:0] ERR_FRAME = 2'd3;

  localparam logic [7:0] OP_HLT = 8'hFF;
  localparam logic [7:0] OP_NOP = 8'h00;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting start detect.
module uart_rx_core import prog_loader_pkg::*; #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       main_clk,
  input  logic       rstn,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);

  // sync[1] is the synchronized line, sync[2] its previous value for edge detection
  logic [2:0]    sync;
  logic          rx_s;
  rx_state_t     state, state_nx;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          tick;

  assign rx_s      = sync[1];
  assign tick      = (cnt == '0);
  assign byte_data = shreg;

  always_comb begin
    state_nx = state;
    case (state)
      RX_IDLE:  if (sync[2] && !rx_s) state_nx = RX_START;
      RX_START: if (tick) state_nx = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick && bit_idx == 3'd7) state_nx = RX_STOP;
      RX_STOP:  if (tick) state_nx = RX_IDLE;
      default:  state_nx = RX_IDLE;
    endcase
  end

  always_ff @(posedge main_clk or negedge rstn) begin
    if (!rstn) begin
      sync       <= 3'b111;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      sync       <= {sync[1:0], rx};
      state      <= state_nx;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      // idle preloads the half-bit wait so the start bit is re-sampled mid-bit
      if (state == RX_IDLE) cnt <= CW'(CLKS_PER_BIT / 2 - 1);
      else if (tick)        cnt <= CW'(CLKS_PER_BIT - 1);
      else                  cnt <= cnt - CW'(1);
      if (state == RX_START && tick) bit_idx <= '0;
      if (state == RX_DATA && tick) begin
        shreg   <= {rx_s, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
      if (state == RX_STOP && tick) begin
        byte_valid <= rx_s;
        frame_err  <= !rx_s;
      end
    end
  end

endmodule

// File: rtl/prog_loader.sv
// Loads a framed, XOR-checked program from UART into a 16x8 memory, then releases the CPU.
module prog_loader import prog_loader_pkg::*; #(
  parameter int         CLK_HZ    = 100000000,
  parameter int         BAUD      = 9600,
  parameter int         DEPTH     = 16,
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input  logic              main_clk,
  input  logic              rstn,
  input  logic              rx,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              cpu_rstn,
  output logic              prog_valid,
  output logic              load_busy,
  output logic              load_done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [4:0]        byte_cnt
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  logic        byte_valid, frame_err;
  logic [7:0]  byte_data;
  load_state_t state, state_nx;
  logic [4:0]  count, fill_addr;
  logic [7:0]  cksum_acc;
  logic [7:0]  mem [DEPTH];
  logic        resync, in_frame, enter_done, enter_err;

  uart_rx_core #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .main_clk   (main_clk),
    .rstn       (rstn),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .frame_err  (frame_err)
  );

  assign rd_data    = mem[rd_addr];
  assign load_busy  = !(state == IDLE || state == DONE);
  assign enter_done = (state_nx == DONE) && (state != DONE);
  assign enter_err  = (state_nx == ERR) && (state != ERR);

  always_comb begin
    state_nx = state;
    resync   = 1'b0;
    in_frame = (state == GET_CNT) || (state == GET_DATA) || (state == GET_CKSUM);
    case (state)
      IDLE, DONE, ERR:
        if (byte_valid && byte_data == SYNC_BYTE) begin
          resync   = 1'b1;
          state_nx = GET_CNT;
        end
      GET_CNT:
        if (byte_valid)
          state_nx = (byte_data == 8'd0 || byte_data > 8'(DEPTH)) ? ERR : GET_DATA;
      GET_DATA:
        if (byte_valid && byte_cnt + 5'd1 == count) state_nx = GET_CKSUM;
      GET_CKSUM:
        if (byte_valid) begin
          if (byte_data != cksum_acc)  state_nx = ERR;
          else if (count == 5'(DEPTH)) state_nx = DONE;
          else                         state_nx = FILL;
        end
      FILL:
        if (fill_addr == 5'(DEPTH - 1)) state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    // framing errors outside a frame are line noise and must not disturb a loaded program
    if (in_frame && frame_err) state_nx = ERR;
  end

  always_ff @(posedge main_clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      count      <= '0;
      fill_addr  <= '0;
      cksum_acc  <= '0;
      byte_cnt   <= '0;
      prog_valid <= 1'b0;
      cpu_rstn   <= 1'b0;
      load_done  <= 1'b0;
      err        <= 1'b0;
      err_code   <= ERR_NONE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= OP_HLT;
    end else begin
      state     <= state_nx;
      load_done <= enter_done;
      cpu_rstn  <= prog_valid && !resync;
      if (resync) begin
        prog_valid <= 1'b0;
        err        <= 1'b0;
        err_code   <= ERR_NONE;
        byte_cnt   <= '0;
        cksum_acc  <= '0;
      end
      if (enter_done) prog_valid <= 1'b1;
      if (enter_err) begin
        err      <= 1'b1;
        err_code <= frame_err ? ERR_FRAME : (state == GET_CNT) ? ERR_COUNT : ERR_CKSUM;
      end
      if (state == GET_CNT && byte_valid) count <= byte_data[4:0];
      if (state == GET_DATA && byte_valid) begin
        mem[byte_cnt[ADDR_W-1:0]] <= byte_data;
        cksum_acc <= cksum_acc ^ byte_data;
        byte_cnt  <= byte_cnt + 5'd1;
      end
      if (state == GET_CKSUM && byte_valid) fill_addr <= count;
      if (state == FILL) begin
        mem[fill_addr[ADDR_W-1:0]] <= OP_HLT;
        fill_addr <= fill_addr + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: frame table plus framing-error, reset and glitch sequences.
module tb_prog_loader;
  import prog_loader_pkg::*;

  localparam int BIT = 10;

  typedef struct {
    logic [0:19][7:0] b;
    int               n;
    logic             ev;
    logic             ee;
    logic [1:0]       ec;
    logic [4:0]       cnt;
  } vec_t;

  logic       clk;
  logic       rstn, rx;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       cpu_rstn, prog_valid, load_busy, load_done, err;
  logic [1:0] err_code;
  logic [4:0] byte_cnt;

  int   total, pass, cyc, stop_cyc, done_cnt, done_cyc;
  logic cr_at_done, pv_at_done, cr_after, done_prev;

  prog_loader #(.CLK_HZ(1000000), .BAUD(100000), .DEPTH(16), .ADDR_W(4), .SYNC_BYTE(8'hA5)) dut (
    .main_clk   (clk),
    .rstn       (rstn),
    .rx         (rx),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cpu_rstn   (cpu_rstn),
    .prog_valid (prog_valid),
    .load_busy  (load_busy),
    .load_done  (load_done),
    .err        (err),
    .err_code   (err_code),
    .byte_cnt   (byte_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0; done_cnt = 0; done_cyc = 0; done_prev = 1'b0;
    cr_at_done = 1'b0; pv_at_done = 1'b0; cr_after = 1'b0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load_done) begin
      done_cnt   <= done_cnt + 1;
      done_cyc   <= cyc;
      cr_at_done <= cpu_rstn;
      pv_at_done <= prog_valid;
    end
    if (done_prev) cr_after <= cpu_rstn;
    done_prev <= load_done;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    stop_cyc = cyc;
    rx = stop_bit;
    repeat (BIT) @(negedge clk);
    if (!stop_bit) begin
      rx = 1'b1;
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic check_mem(input logic [15:0][7:0] em, input string tag);
    for (int i = 0; i < 16; i++) begin
      rd_addr = 4'(i);
      #1;
      check($sformatf("%s mem[%0d]", tag, i), rd_data, em[i]);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " prog_valid"}, prog_valid, 0);
    check({tag, " cpu_rstn"},   cpu_rstn,   0);
    check({tag, " load_busy"},  load_busy,  0);
    check({tag, " load_done"},  load_done,  0);
    check({tag, " err"},        err,        0);
    check({tag, " err_code"},   err_code,   0);
    check({tag, " byte_cnt"},   byte_cnt,   0);
  endtask

  function automatic vec_t mk(input int n, input logic [63:0] raw, input logic ev, input logic ee,
                              input logic [1:0] ec, input logic [4:0] cnt);
    vec_t v;
    v.b = '0; v.n = n; v.ev = ev; v.ee = ee; v.ec = ec; v.cnt = cnt;
    for (int k = 0; k < n; k++) v.b[k] = raw[8*(n-1-k) +: 8];
    return v;
  endfunction

  initial begin
    vec_t             vecs [7];
    int               lat  [7];
    logic [15:0][7:0] em;
    logic [7:0]       cks, d;
    int               d0, base;

    total = 0; pass = 0; stop_cyc = 0;
    rstn = 1'b0; rx = 1'b1; rd_addr = '0;

    vecs[0] = mk(6, 64'hA5_03_93_63_15_E5,       1'b1, 1'b0, ERR_NONE,  5'd3);
    vecs[1] = mk(2, 64'hA5_00,                   1'b0, 1'b1, ERR_COUNT, 5'd0);
    vecs[2] = mk(5, 64'hA5_02_11_22_00,          1'b0, 1'b1, ERR_CKSUM, 5'd2);
    vecs[3] = mk(8, 64'hA5_05_01_02_04_08_10_1F, 1'b1, 1'b0, ERR_NONE,  5'd5);
    vecs[4] = mk(2, 64'hA5_11,                   1'b0, 1'b1, ERR_COUNT, 5'd0);
    vecs[5] = mk(5, 64'hA5_02_A5_A5_00,          1'b1, 1'b0, ERR_NONE,  5'd2);
    vecs[6] = mk(0, 64'h0,                       1'b1, 1'b0, ERR_NONE,  5'd16);
    vecs[6].n = 19;
    vecs[6].b[0] = 8'hA5;
    vecs[6].b[1] = 8'h10;
    cks = 8'h00;
    for (int k = 0; k < 16; k++) begin
      d = 8'h3C ^ 8'(k * 7);
      vecs[6].b[2+k] = d;
      cks ^= d;
    end
    vecs[6].b[18] = cks;
    for (int v = 0; v < 7; v++) lat[v] = 0;

    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    em = {16{8'hFF}};
    check_mem(em, "reset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      d0 = done_cnt;
      for (int k = 0; k < vecs[v].n; k++) send_byte(vecs[v].b[k], 1'b1);
      repeat (30) @(negedge clk);
      check($sformatf("v%0d prog_valid", v), prog_valid, vecs[v].ev);
      check($sformatf("v%0d cpu_rstn", v),   cpu_rstn,   vecs[v].ev);
      check($sformatf("v%0d err", v),        err,        vecs[v].ee);
      check($sformatf("v%0d err_code", v),   err_code,   vecs[v].ec);
      check($sformatf("v%0d byte_cnt", v),   byte_cnt,   vecs[v].cnt);
      check($sformatf("v%0d done pulses", v), done_cnt - d0, vecs[v].ev ? 1 : 0);
      if (vecs[v].ev) begin
        lat[v] = done_cyc - stop_cyc;
        check($sformatf("v%0d prog_valid at done", v), pv_at_done, 1);
        check($sformatf("v%0d cpu_rstn at done", v),   cr_at_done, 0);
        check($sformatf("v%0d cpu_rstn after done", v), cr_after,  1);
        check($sformatf("v%0d load_busy", v),          load_busy,  0);
        for (int i = 0; i < 16; i++)
          em[i] = (i < int'(vecs[v].cnt)) ? vecs[v].b[2+i] : 8'hFF;
        check_mem(em, $sformatf("v%0d", v));
        @(negedge clk);
      end
    end

    // full-depth load skips FILL, so load_done lands while the checksum stop bit is on the line
    base = lat[6];
    check("lat16 within stop bit", (base >= 4 && base <= BIT) ? 1 : 0, 1);
    for (int v = 0; v < 6; v++)
      if (vecs[v].ev)
        check($sformatf("v%0d fill latency", v), lat[v], base + 16 - int'(vecs[v].cnt));

    // stop bit forced low mid-GET_DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b0);
    repeat (5) @(negedge clk);
    check("frame err", err, 1);
    check("frame err_code", err_code, ERR_FRAME);
    check("frame prog_valid", prog_valid, 0);
    check("frame cpu_rstn", cpu_rstn, 0);
    check("frame byte_cnt", byte_cnt, 1);
    d0 = done_cnt;
    send_byte(8'h3C, 1'b1);
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h5A, 1'b1);
    send_byte(8'h5A, 1'b1);
    repeat (30) @(negedge clk);
    check("reload err", err, 0);
    check("reload err_code", err_code, ERR_NONE);
    check("reload prog_valid", prog_valid, 1);
    check("reload done pulses", done_cnt - d0, 1);
    em = {16{8'hFF}};
    em[0] = 8'h5A;
    check_mem(em, "reload");

    // reset in the middle of GET_DATA
    send_byte(8'hA5, 1'b1);
    send_byte(8'h04, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    repeat (3) @(negedge clk);
    check("midframe busy before reset", load_busy, 1);
    rstn = 1'b0;
    @(negedge clk);
    check_idle_outputs("midreset");
    em = {16{8'hFF}};
    check_mem(em, "midreset");
    @(negedge clk);
    rstn = 1'b1;
    repeat (5) @(negedge clk);

    // 2-clock low glitch in idle must not be taken as a start bit
    rx = 1'b0;
    repeat (2) @(negedge clk);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    d0 = done_cnt;
    send_byte(8'hA5, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hC3, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch prog_valid", prog_valid, 1);
    check("glitch err", err, 0);
    check("glitch done pulses", done_cnt - d0, 1);
    em = {16{8'hFF}};
    em[0] = 8'hC3;
    check_mem(em, "glitch");

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
